// File: rtl/jk_universal_reg.sv
// WIDTH-bit register bank with per-bit JK semantics.
// Modes: load, JK, masked toggle, shift, rotate, count. Also serial out, carry and changed flags.
module jk_universal_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout,
  output logic             carry,
  output logic             changed
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_reg, q_next, jk_next;
  logic             sout_reg, sout_next;
  logic             carry_reg, carry_next;
  logic             changed_reg, changed_next;

  // Characteristic JK equation: Q+ = J & ~Q | ~K & Q
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
    assign jk_next[gi] = (j[gi] & ~q_reg[gi]) | (~k[gi] & q_reg[gi]);
  end

  always_comb begin
    q_next    = q_reg;
    sout_next = sout_reg;
    case (mode)
      3'b000: q_next = q_reg;
      3'b001: q_next = d;
      3'b010: q_next = jk_next;
      3'b011: q_next = q_reg ^ k;
      3'b100: begin
        q_next    = {q_reg[WIDTH-2:0], sin};
        sout_next = q_reg[WIDTH-1];
      end
      3'b101: begin
        q_next    = {sin, q_reg[WIDTH-1:1]};
        sout_next = q_reg[0];
      end
      3'b110: begin
        q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        sout_next = q_reg[WIDTH-1];
      end
      3'b111: q_next = q_reg + ONE;
    endcase
    carry_next   = (mode == 3'b111) && (&q_reg);
    changed_next = (q_next != q_reg);
  end

  // Disabled edges hold q and sout but drop both flags so they remain single-edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= RST_VAL;
      sout_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      changed_reg <= 1'b0;
    end else if (en) begin
      q_reg       <= q_next;
      sout_reg    <= sout_next;
      carry_reg   <= carry_next;
      changed_reg <= changed_next;
    end else begin
      carry_reg   <= 1'b0;
      changed_reg <= 1'b0;
    end
  end

  assign q       = q_reg;
  assign q_bar   = ~q_reg;
  assign sout    = sout_reg;
  assign carry   = carry_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_jk_universal_reg.sv
// Directed-vector bench for jk_universal_reg (WIDTH=8), with a second instance for RST_VAL=8'hA5.
module tb_jk_universal_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d, j, k;
  logic       sin;
  logic [7:0] q, q_bar, q_a, q_bar_a;
  logic       sout, carry, changed, sout_a, carry_a, changed_a;

  int total = 0;
  int bad   = 0;

  jk_universal_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k), .sin(sin),
    .q(q), .q_bar(q_bar), .sout(sout), .carry(carry), .changed(changed)
  );

  jk_universal_reg #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut_a5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k), .sin(sin),
    .q(q_a), .q_bar(q_bar_a), .sout(sout_a), .carry(carry_a), .changed(changed_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one set of inputs, then sample 1 ns after the following rising edge.
  task automatic step(input logic en_i, input logic [2:0] mode_i, input logic [7:0] d_i,
                      input logic [7:0] j_i, input logic [7:0] k_i, input logic sin_i);
    en = en_i; mode = mode_i; d = d_i; j = j_i; k = k_i; sin = sin_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = '0; j = '0; k = '0; sin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset: AD << 1 gives 5A with sout=1, then reset lands between edges.
    step(1'b1, 3'b001, 8'hAD, 8'h00, 8'h00, 1'b0);
    step(1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_q", q, 8'h5A);
    chk("pre_rst_sout", sout, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_q_bar", q_bar, 8'hFF);
    chk("rst_sout", sout, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_changed", changed, 1'b0);
    chk("rst_a5_q", q_a, 8'hA5);
    chk("rst_a5_q_bar", q_bar_a, 8'h5A);
    @(negedge clk);
    rst = 1'b0;

    // Load then JK: bits 7,6 clear, 5,4 hold, 3,2 set, 1,0 toggle 0->1 => 3F.
    step(1'b1, 3'b001, 8'hF0, 8'h00, 8'h00, 1'b0);
    chk("load_q", q, 8'hF0);
    chk("load_changed", changed, 1'b1);
    step(1'b1, 3'b010, 8'h00, 8'h0F, 8'hC3, 1'b0);
    chk("jk_q", q, 8'h3F);
    chk("jk_q_bar", q_bar, 8'hC0);
    chk("jk_changed", changed, 1'b1);

    // Masked toggle ignores j.
    step(1'b1, 3'b011, 8'h00, 8'hFF, 8'h0F, 1'b0);
    chk("tog_q", q, 8'h30);

    // Hold mode reports no change.
    step(1'b1, 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    chk("hold_q", q, 8'h30);
    chk("hold_changed", changed, 1'b0);

    // Shift left twice, then shift right with sin=1.
    step(1'b1, 3'b001, 8'h81, 8'h00, 8'h00, 1'b0);
    step(1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("shl1_q", q, 8'h02);
    chk("shl1_sout", sout, 1'b1);
    step(1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("shl2_q", q, 8'h04);
    chk("shl2_sout", sout, 1'b0);
    step(1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("shr_q", q, 8'h82);
    chk("shr_sout", sout, 1'b0);

    // Rotate left, with sin driven high to show it is ignored.
    step(1'b1, 3'b001, 8'h81, 8'h00, 8'h00, 1'b0);
    step(1'b1, 3'b110, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("rol_q", q, 8'h03);
    chk("rol_sout", sout, 1'b1);
    // Load leaves sout unchanged.
    step(1'b1, 3'b001, 8'h55, 8'h00, 8'h00, 1'b0);
    chk("load_sout_hold", sout, 1'b1);

    // Count across the wrap.
    step(1'b1, 3'b001, 8'hFE, 8'h00, 8'h00, 1'b0);
    step(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("cnt1_q", q, 8'hFF);
    chk("cnt1_carry", carry, 1'b0);
    step(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("cnt2_q", q, 8'h00);
    chk("cnt2_carry", carry, 1'b1);
    chk("cnt2_changed", changed, 1'b1);
    step(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("cnt3_q", q, 8'h01);
    chk("cnt3_carry", carry, 1'b0);

    // Enable low: hold q and sout (sout=1 from rotate), flags stay clear.
    step(1'b1, 3'b001, 8'h33, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b111, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      chk($sformatf("en0_q_%0d", i), q, 8'h33);
      chk($sformatf("en0_carry_%0d", i), carry, 1'b0);
      chk($sformatf("en0_changed_%0d", i), changed, 1'b0);
      chk($sformatf("en0_sout_%0d", i), sout, 1'b1);
    end
    step(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("en1_hold_q", q, 8'h33);
    chk("en1_hold_changed", changed, 1'b0);

    // Reset aborts a count mid-stream; the A5 instance returns to A5.
    step(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst2_q", q, 8'h00);
    chk("rst2_a5_q", q_a, 8'hA5);
    chk("rst2_changed", changed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("post_rst_cnt_q", q, 8'h01);
    chk("post_rst_cnt_a5_q", q_a, 8'hA6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
